// File: rtl/l2_group_accum.sv
// rtl/l2_group_accum.sv - L2 group accumulator for un-normalised L1 adder results
//
// Purpose: aligns each accepted L1 beat (magnitude, exponent, sign) to a common
// fixed-point scale, sums a group of beats into a saturating two's-complement
// accumulator and offers the group sum through a valid/ready handshake.
//
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   prec_mode_i            precision mode (2'b11 = FP4, others = INT8/FP8)
//   in_valid_i/in_ready_o  beat handshake
//   in_mant_i/in_exp_i     beat magnitude and exponent
//   in_sign_i              beat sign (1 = negative)
//   in_last_i              beat closes the current group early
//   out_valid_o/out_ready_i result handshake
//   out_data_o             signed group sum
//   out_ovf_o              saturation or shift clamp seen in the group
//   out_count_o            number of beats in the group
module l2_group_accum #(
  parameter int ACC_W     = 32,
  parameter int GROUP_LEN = 8,
  parameter int MAX_SHIFT = 15
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [1:0]                           prec_mode_i,
  input  logic                                 in_valid_i,
  output logic                                 in_ready_o,
  input  logic [9:0]                           in_mant_i,
  input  logic [5:0]                           in_exp_i,
  input  logic                                 in_sign_i,
  input  logic                                 in_last_i,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  output logic [ACC_W-1:0]                     out_data_o,
  output logic                                 out_ovf_o,
  output logic [$clog2(GROUP_LEN+1)-1:0]       out_count_o
);

  localparam int CW = $clog2(GROUP_LEN + 1);

  typedef enum logic {S_ACC, S_OUT} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [1:0]       mode_q, mode_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;
  logic             out_ovf_q, out_ovf_d;
  logic [CW-1:0]    out_count_q, out_count_d;

  logic [1:0]       eff_mode;
  logic             clamp;
  logic [5:0]       shift;
  logic [ACC_W-1:0] mag;
  logic [ACC_W-1:0] term;
  logic [ACC_W:0]   sum_wide;
  logic             sat_ovf;
  logic [ACC_W-1:0] sat_sum;
  logic             accept;
  logic             close;

  assign in_ready_o  = (state_q == S_ACC);
  assign out_valid_o = (state_q == S_OUT);
  assign out_data_o  = out_data_q;
  assign out_ovf_o   = out_ovf_q;
  assign out_count_o = out_count_q;

  always_comb begin
    // The first beat of a group uses the live mode; later beats use the latch.
    eff_mode = (cnt_q == '0) ? prec_mode_i : mode_q;
    // FP4 beats arrive with the exponent already applied by L1.
    clamp    = (eff_mode != 2'b11) && (in_exp_i > 6'(MAX_SHIFT));
    if (eff_mode == 2'b11) begin
      shift = 6'd0;
    end else if (clamp) begin
      shift = 6'(MAX_SHIFT);
    end else begin
      shift = in_exp_i;
    end
    mag      = ACC_W'(in_mant_i) << shift;
    term     = in_sign_i ? (~mag + ACC_W'(1)) : mag;
    sum_wide = {acc_q[ACC_W-1], acc_q} + {term[ACC_W-1], term};
    // Extra top bit disagreeing with the result sign means the add wrapped.
    sat_ovf  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    if (sat_ovf) begin
      sat_sum = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      sat_sum = sum_wide[ACC_W-1:0];
    end
    accept = in_valid_i && (state_q == S_ACC);
    close  = accept && (in_last_i || (cnt_q == CW'(GROUP_LEN - 1)));
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    mode_d      = mode_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    out_count_d = out_count_q;
    case (state_q)
      S_ACC: begin
        if (accept) begin
          acc_d = sat_sum;
          cnt_d = cnt_q + CW'(1);
          ovf_d = ovf_q | clamp | sat_ovf;
          if (cnt_q == '0) begin
            mode_d = prec_mode_i;
          end
          if (close) begin
            out_data_d  = sat_sum;
            out_ovf_d   = ovf_q | clamp | sat_ovf;
            out_count_d = cnt_q + CW'(1);
            state_d     = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (out_ready_i) begin
          state_d = S_ACC;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = S_ACC;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      mode_q      <= 2'b00;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      mode_q      <= mode_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      out_count_q <= out_count_d;
    end
  end

endmodule
